piso_serializer: RTL and testbench

- Parallel-in, serial-out serializer; the transmit-side counterpart to the serial-in/parallel-out shift_register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Presents the word one bit per shift_en strobe on data_out, with a frame_done pulse after the last bit.
- Drives the serial link, or a shift_register in loopback, in the datapath.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer.sv | 81 ++++++++
 tb/tb_piso_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared state encoding and counter sizing for the PISO serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-count width for a given word length (never below one bit).
    function automatic int piso_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: first bit on data_out one cycle after load, one bit per shift_en.
// Backpressure: load_ready only in IDLE or on the last-bit edge; without shift_en the bit holds forever.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int               CNT_W = piso_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    piso_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             load_fire;

    // The last-bit edge doubles as a load slot so consecutive frames have no gap.
    assign last_bit   = (state == SHIFT) && (cnt == LAST) && shift_en;
    assign load_ready = !reset && ((state == IDLE) || last_bit);
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            data_out   <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_bit;
            if (load_fire) begin
                state     <= SHIFT;
                sreg      <= load_data;
                cnt       <= '0;
                data_out  <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
                bit_valid <= 1'b1;
                busy      <= 1'b1;
            end else if (last_bit) begin
                state     <= IDLE;
                sreg      <= '0;
                cnt       <= '0;
                data_out  <= 1'b0;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
            end else if ((state == SHIFT) && shift_en) begin
                // data_out tracks the output end of the register after the shift.
                sreg     <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                cnt      <= cnt + CNT_W'(1);
                data_out <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
            end
        end
    end

    a_cnt_bound: assert property (@(posedge clock) disable iff (reset)
        int'(cnt) < WIDTH);

    a_idle_cnt_clear: assert property (@(posedge clock) disable iff (reset)
        (state == IDLE) |-> (cnt == '0));

    a_ready_only_last: assert property (@(posedge clock) disable iff (reset)
        (load_ready && (state == SHIFT)) |-> ((cnt == LAST) && shift_en));

    a_done_single: assert property (@(posedge clock) disable iff (reset)
        frame_done |=> !frame_done);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: vector table, directed frame sequences and a random run vs a word/position model.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         lv    = 1'b0;
    logic         se    = 1'b0;
    logic [W-1:0] ld    = '0;

    logic m_rdy, m_dout, m_bv, m_busy, m_fd;
    logic l_rdy, l_dout, l_bv, l_busy, l_fd;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .load_valid(lv), .load_data(ld), .load_ready(m_rdy),
        .shift_en(se), .data_out(m_dout), .bit_valid(m_bv), .busy(m_busy), .frame_done(m_fd)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .load_valid(lv), .load_data(ld), .load_ready(l_rdy),
        .shift_en(se), .data_out(l_dout), .bit_valid(l_bv), .busy(l_busy), .frame_done(l_fd)
    );

    int total = 0;
    int bad   = 0;

    // Model: word in flight and number of its bits not yet consumed (index 0 = MSB-first, 1 = LSB-first).
    logic [W-1:0] wd [2];
    int           rem [2];
    bit           mfd [2];

    logic         exp_rdy_last;
    logic [15:0]  cap_m, cap_l;
    int           cyc;
    int           fd_log[$];

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
        logic         s;
        logic         r;
        logic         rdy;
        logic         dout;
        logic         bv;
        logic         fd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic mdl_bit(input int i);
        int pos;
        if (rem[i] == 0) return 1'b0;
        pos = W - rem[i];
        return (i == 0) ? wd[i][W-1-pos] : wd[i][pos];
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d, input logic s, input logic r);
        logic er;
        lv = v; ld = d; se = s; reset = r;
        #1;
        er = !r && ((rem[0] == 0) || ((rem[0] == 1) && s));
        exp_rdy_last = er;
        chk("load_ready_m", {31'd0, m_rdy}, {31'd0, er});
        chk("load_ready_l", {31'd0, l_rdy}, {31'd0, er});
        if (m_bv && s) cap_m = {cap_m[14:0], m_dout};
        if (l_bv && s) cap_l = {cap_l[14:0], l_dout};
        @(posedge clock);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                rem[i] = 0;
                mfd[i] = 1'b0;
            end else begin
                mfd[i] = (rem[i] == 1) && s;
                if (er && v) begin
                    wd[i]  = d;
                    rem[i] = W;
                end else if ((rem[i] > 0) && s) begin
                    rem[i] = rem[i] - 1;
                end
            end
        end
        cyc++;
        #1;
        chk("data_out_m",   {31'd0, m_dout}, {31'd0, mdl_bit(0)});
        chk("data_out_l",   {31'd0, l_dout}, {31'd0, mdl_bit(1)});
        chk("bit_valid_m",  {31'd0, m_bv},   {31'd0, rem[0] > 0});
        chk("busy_l",       {31'd0, l_busy}, {31'd0, rem[1] > 0});
        chk("frame_done_m", {31'd0, m_fd},   {31'd0, mfd[0]});
        chk("frame_done_l", {31'd0, l_fd},   {31'd0, mfd[1]});
        if (m_fd) fd_log.push_back(cyc);
    endtask

    task automatic frame(input logic [W-1:0] w);
        step(1'b1, w, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    logic [W-1:0] lb_words [3];

    initial begin
        logic         pv;
        logic [W-1:0] pd;
        int           idx;
        int           c8;

        for (int i = 0; i < 2; i++) begin rem[i] = 0; mfd[i] = 1'b0; wd[i] = '0; end
        cyc = 0; cap_m = '0; cap_l = '0;

        // Basic MSB-first frame of 8'hA5 with shift_en every cycle.
        tbl[0]  = '{v:1'b0, d:8'h00, s:1'b0, r:1'b1, rdy:1'b0, dout:1'b0, bv:1'b0, fd:1'b0};
        tbl[1]  = '{v:1'b1, d:8'hA5, s:1'b0, r:1'b0, rdy:1'b1, dout:1'b1, bv:1'b1, fd:1'b0};
        tbl[2]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b0, bv:1'b1, fd:1'b0};
        tbl[3]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b1, bv:1'b1, fd:1'b0};
        tbl[4]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b0, bv:1'b1, fd:1'b0};
        tbl[5]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b0, bv:1'b1, fd:1'b0};
        tbl[6]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b1, bv:1'b1, fd:1'b0};
        tbl[7]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b0, bv:1'b1, fd:1'b0};
        tbl[8]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b0, dout:1'b1, bv:1'b1, fd:1'b0};
        tbl[9]  = '{v:1'b0, d:8'h00, s:1'b1, r:1'b0, rdy:1'b1, dout:1'b0, bv:1'b0, fd:1'b1};
        tbl[10] = '{v:1'b0, d:8'h00, s:1'b0, r:1'b0, rdy:1'b1, dout:1'b0, bv:1'b0, fd:1'b0};

        for (int t = 0; t < 11; t++) begin
            step(tbl[t].v, tbl[t].d, tbl[t].s, tbl[t].r);
            chk($sformatf("tbl%0d_ready", t), {31'd0, m_rdy_seen()}, {31'd0, tbl[t].rdy});
            chk($sformatf("tbl%0d_dout", t),  {31'd0, m_dout}, {31'd0, tbl[t].dout});
            chk($sformatf("tbl%0d_bv", t),    {31'd0, m_bv},   {31'd0, tbl[t].bv});
            chk($sformatf("tbl%0d_busy", t),  {31'd0, m_busy}, {31'd0, tbl[t].bv});
            chk($sformatf("tbl%0d_fd", t),    {31'd0, m_fd},   {31'd0, tbl[t].fd});
        end
        chk("basic_bits", {24'd0, cap_m[7:0]}, 32'hA5);

        // Stalled shift: shift_en alternates, each bit held two cycles.
        cap_m = '0; fd_log.delete(); c8 = -1;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, '0, (k % 2) == 0, 1'b0);
            if (k == 14) c8 = cyc;
        end
        chk("stall_bits", {24'd0, cap_m[7:0]}, 32'hA5);
        chk("stall_fd_count", fd_log.size(), 1);
        chk("stall_fd_cycle", fd_log[0], c8);

        // Back-to-back: requester holds A5 then 3C, shift_en continuous.
        cap_m = '0; fd_log.delete(); idx = 0;
        for (int k = 0; k < 20; k++) begin
            step(idx < 2, (idx == 0) ? 8'hA5 : 8'h3C, 1'b1, 1'b0);
            if ((idx < 2) && exp_rdy_last) idx++;
        end
        chk("b2b_bits", {16'd0, cap_m}, 32'hA53C);
        chk("b2b_fd_count", fd_log.size(), 2);
        chk("b2b_fd_spacing", fd_log[1] - fd_log[0], 8);

        // Reset mid-frame, then a fresh frame right after reset falls.
        fd_log.delete();
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("rst_dout", {31'd0, m_dout}, 32'd0);
        chk("rst_bv",   {31'd0, m_bv},   32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_fd",   {31'd0, m_fd},   32'd0);
        cap_m = '0;
        frame(8'h81);
        chk("rst_ready_after", {31'd0, exp_rdy_last}, 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_new_bits", {24'd0, cap_m[7:0]}, 32'h81);
        chk("rst_no_abort_done", fd_log.size(), 1);

        // LSB-first instance on 8'h01.
        cap_l = '0;
        frame(8'h01);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("lsb_bits", {24'd0, cap_l[7:0]}, 32'h80);

        // Loopback: bits accepted by a downstream shift-in register rebuild the word.
        lb_words[0] = 8'hA5; lb_words[1] = 8'h5A; lb_words[2] = 8'h00;
        for (int j = 0; j < 3; j++) begin
            cap_m = 16'hFFFF;
            frame(lb_words[j]);
            step(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("loop_%0h", lb_words[j]), {24'd0, cap_m[7:0]}, {24'd0, lb_words[j]});
        end

        // Random traffic with held requests, random stalls and rare resets.
        pv = 1'b0; pd = '0;
        for (int n = 0; n < 3000; n++) begin
            logic s, r;
            if (!pv && ($urandom_range(0, 3) == 0)) begin
                pv = 1'b1;
                pd = W'($urandom);
            end
            s = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 199) == 0);
            step(pv, pd, s, r);
            if (pv && exp_rdy_last) pv = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // load_ready observed just before the most recent edge, captured by step().
    logic rdy_seen_q;
    always @(posedge clock) rdy_seen_q <= m_rdy;
    function automatic logic m_rdy_seen();
        return rdy_seen_q;
    endfunction

endmodule
